adc_frame_packer: RTL and testbench

- Sits directly upstream of the window function stage.
- Takes a free-running, single-sample ADC stream that has no backpressure and packs BUS_NUM consecutive samples into one bus beat.
- Cuts the stream into frames of FFT_SIZE samples and asserts tlast on the final beat of each frame.
- Buffers whole frames in a beat FIFO for the AXIS consumer. A frame that cannot be fully buffered is dropped as a whole, so the downstream stage only ever sees complete, tlast-terminated packets.

---
 rtl/adc_frame_packer.sv | 205 ++++++++++++++++++++
 tb/tb_adc_frame_packer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_frame_packer
//  Description : Packs a free-running ADC sample stream into BUS_NUM-lane
//                beats, cuts it into FFT_SIZE-sample frames, and buffers
//                whole frames in a beat FIFO feeding an AXIS consumer.
//                Frames that cannot be fully buffered are dropped whole.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_frame_packer #(
  parameter int FFT_SIZE   = 8192,
  parameter int BUS_NUM    = 2,
  parameter int FIFO_DEPTH = FFT_SIZE / BUS_NUM,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      in_tvalid,
  input  logic [31:0]               in_tdata,
  output logic                      out_tvalid,
  input  logic                      out_tready,
  output logic                      out_tlast,
  output logic [BUS_NUM-1:0][31:0]  out_tdata,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic                      busy
);

  localparam int FRAME_BEATS = FFT_SIZE / BUS_NUM;
  localparam int SMP_W       = $clog2(FFT_SIZE);
  localparam int LANE_W      = $clog2(BUS_NUM);
  localparam int PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W       = $clog2(FIFO_DEPTH) + 2;
  localparam int BEAT_W      = BUS_NUM * 32;

  localparam logic [OCC_W-1:0]  ADMIT_MAX = OCC_W'(FIFO_DEPTH - FRAME_BEATS);
  localparam logic [SMP_W-1:0]  LAST_SMP  = SMP_W'(FFT_SIZE - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BUS_NUM - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t                      state_q;
  logic [SMP_W-1:0]            smp_cnt_q;
  logic [CNT_W-1:0]            drop_cnt_q;
  logic [BUS_NUM-2:0][31:0]    lanes_q;

  logic                        wr_valid_q;
  logic                        wr_last_q;
  logic [BUS_NUM-1:0][31:0]    wr_data_q;

  logic [BEAT_W:0]             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q;
  logic [PTR_W-1:0]            rd_ptr_q;
  logic [OCC_W-1:0]            mem_cnt_q;
  logic [OCC_W-1:0]            mem_cnt_d;

  logic                        out_valid_q;
  logic                        out_last_q;
  logic [BUS_NUM-1:0][31:0]    out_data_q;

  logic [LANE_W-1:0]           w_lane;
  logic                        w_start;
  logic                        w_admit;
  logic                        w_cap;
  logic                        w_beat_done;
  logic [OCC_W-1:0]            w_occ;
  logic                        w_pop;
  logic                        w_out_free;
  logic                        w_load_mem;
  logic                        w_bypass;
  logic                        w_mem_wr;

  // Occupancy counts the write-stage beat too, so admission is exact.
  assign w_occ       = mem_cnt_q + OCC_W'(out_valid_q) + OCC_W'(wr_valid_q);
  assign w_lane      = smp_cnt_q[LANE_W-1:0];
  assign w_start     = in_tvalid && (smp_cnt_q == '0);
  assign w_admit     = en && (w_occ <= ADMIT_MAX);
  assign w_cap       = in_tvalid && (w_start ? w_admit : (state_q == S_CAPTURE));
  assign w_beat_done = w_cap && (w_lane == LAST_LANE);

  // Output register is refilled from the memory first, else straight from the write stage.
  assign w_pop      = out_valid_q && out_tready;
  assign w_out_free = !out_valid_q || w_pop;
  assign w_load_mem = w_out_free && (mem_cnt_q != '0);
  assign w_bypass   = w_out_free && (mem_cnt_q == '0) && wr_valid_q;
  assign w_mem_wr   = wr_valid_q && !w_bypass;

  // Frame FSM, free-running sample counter and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      smp_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (in_tvalid) begin
      smp_cnt_q <= smp_cnt_q + 1'b1;
      if (w_start) begin
        if (w_admit) begin
          state_q <= S_CAPTURE;
        end else begin
          state_q <= S_DISCARD;
          if (en && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
          end
        end
      end else if (smp_cnt_q == LAST_SMP) begin
        state_q <= S_IDLE;
      end
    end
  end

  // Holding registers for all lanes except the last, which completes the beat.
  generate
    for (genvar i = 0; i < BUS_NUM - 1; i++) begin : g_lane
      always_ff @(posedge clk) begin
        if (rst) begin
          lanes_q[i] <= '0;
        end else if (w_cap && (w_lane == LANE_W'(i))) begin
          lanes_q[i] <= in_tdata;
        end
      end
    end
  endgenerate

  // Write stage: one complete beat, tagged with tlast on the frame's final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid_q <= 1'b0;
      wr_last_q  <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= w_beat_done;
      if (w_beat_done) begin
        wr_data_q <= {in_tdata, lanes_q};
        wr_last_q <= (smp_cnt_q == LAST_SMP);
      end
    end
  end

  // Beat memory storage; contents are don't-care until pointed at.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      mem_q[wr_ptr_q] <= {wr_last_q, wr_data_q};
    end
  end

  // Memory fill level changes only when a write and a read do not coincide.
  always_comb begin
    mem_cnt_d = mem_cnt_q;
    if (w_mem_wr && !w_load_mem) begin
      mem_cnt_d = mem_cnt_q + 1'b1;
    end else if (!w_mem_wr && w_load_mem) begin
      mem_cnt_d = mem_cnt_q - 1'b1;
    end
  end

  // Memory pointers and fill level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      if (w_mem_wr) begin
        wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (w_load_mem) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  // Registered AXIS output; holds its beat until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (w_out_free) begin
      if (w_load_mem) begin
        {out_last_q, out_data_q} <= mem_q[rd_ptr_q];
        out_valid_q              <= 1'b1;
      end else if (w_bypass) begin
        out_last_q  <= wr_last_q;
        out_data_q  <= wr_data_q;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_tvalid = out_valid_q;
  assign out_tlast  = out_last_q;
  assign out_tdata  = out_data_q;
  assign drop_cnt   = drop_cnt_q;
  assign busy       = (state_q == S_CAPTURE) || (w_occ != '0);

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_frame_packer
//  Description : Scoreboard bench for adc_frame_packer (16-sample frames,
//                2 lanes, 8-beat FIFO, 2-bit drop counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_frame_packer;

  localparam int FFT_SIZE   = 16;
  localparam int BUS_NUM    = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 2;
  localparam int BEATS      = FFT_SIZE / BUS_NUM;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     en = 1'b1;
  logic                     in_tvalid = 1'b0;
  logic [31:0]              in_tdata = 32'h0;
  logic                     out_tvalid;
  logic                     out_tready = 1'b1;
  logic                     out_tlast;
  logic [BUS_NUM-1:0][31:0] out_tdata;
  logic [CNT_W-1:0]         drop_cnt;
  logic                     busy;

  logic                     rdy_fixed = 1'b1;
  logic                     rdy_rand = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [64:0] exp_q[$];

  adc_frame_packer #(
    .FFT_SIZE  (FFT_SIZE),
    .BUS_NUM   (BUS_NUM),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_tvalid (in_tvalid),
    .in_tdata  (in_tdata),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tlast (out_tlast),
    .out_tdata (out_tdata),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [31:0] d);
    in_tvalid = 1'b1;
    in_tdata  = d;
    tick();
    in_tvalid = 1'b0;
    in_tdata  = 32'hDEAD_BEEF;
  endtask

  // One frame of samples base..base+15; expected beats are queued if it should be kept.
  task automatic send_frame(input logic [31:0] base, input bit keep, input bit gaps,
                            input bit lat, input int en_at);
    logic [64:0] e;
    if (keep) begin
      for (int k = 0; k < BEATS; k++) begin
        e = {(k == BEATS - 1), 32'(base + 32'(2 * k + 1)), 32'(base + 32'(2 * k))};
        exp_q.push_back(e);
      end
    end
    for (int i = 0; i < FFT_SIZE; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) tick();
      if (i == en_at) en = 1'b1;
      send_sample(base + 32'(i));
      if (lat && i == 1) chk("latency_n1_valid", 64'(out_tvalid), 64'd0);
      if (lat && i == 2) chk("latency_n2_valid", 64'(out_tvalid), 64'd1);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("drain_idle", 64'(ok), 64'd1);
    tick();
  endtask

  // Ready generator: fixed level or random per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stability while stalled.
  initial begin
    logic [64:0] e;
    logic [63:0] prev_data;
    logic        prev_last;
    bit          prev_stall;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(out_tvalid), 64'd1);
          chk("stall_data", out_tdata, prev_data);
          chk("stall_last", 64'(out_tlast), 64'(prev_last));
        end
        if (out_tvalid && out_tready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got %h last=%0d, expected no beat", out_tdata, out_tlast);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", out_tdata, e[63:0]);
            chk("beat_last", 64'(out_tlast), 64'(e[64]));
          end
        end
        prev_stall = out_tvalid && !out_tready;
        prev_data  = out_tdata;
        prev_last  = out_tlast;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_tlast", 64'(out_tlast), 64'd0);
    chk("rst_tdata", out_tdata, 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Continuous capture with latency check
    send_frame(32'h100, 1'b1, 1'b0, 1'b1, -1);
    wait_idle();
    chk("s1_drop", 64'(drop_cnt), 64'd0);

    // Back-to-back frame with no room: second frame is dropped and counted
    send_frame(32'h180, 1'b1, 1'b0, 1'b0, -1);
    send_frame(32'h1C0, 1'b0, 1'b0, 1'b0, -1);
    chk("b2b_drop", 64'(drop_cnt), 64'd1);
    wait_idle();

    // en low at frame start: skipped, not counted; en rising mid-frame has no effect
    en = 1'b0;
    send_frame(32'h200, 1'b0, 1'b0, 1'b0, 8);
    send_frame(32'h300, 1'b1, 1'b0, 1'b0, -1);
    wait_idle();
    chk("en_skip_drop", 64'(drop_cnt), 64'd1);

    // Stalled consumer: first frame fills the FIFO, second is dropped
    rdy_fixed = 1'b0;
    tick();
    send_frame(32'h400, 1'b1, 1'b0, 1'b0, -1);
    send_frame(32'h500, 1'b0, 1'b0, 1'b0, -1);
    chk("stall_drop", 64'(drop_cnt), 64'd2);
    chk("stall_head_valid", 64'(out_tvalid), 64'd1);
    chk("stall_head_data", out_tdata, {32'h401, 32'h400});
    chk("stall_busy", 64'(busy), 64'd1);
    rdy_fixed = 1'b1;
    wait_idle();
    send_frame(32'h600, 1'b1, 1'b0, 1'b0, -1);
    wait_idle();

    // Random input gaps and random ready
    rdy_rand = 1'b1;
    send_frame(32'h700, 1'b1, 1'b1, 1'b0, -1);
    wait_idle();
    send_frame(32'h800, 1'b1, 1'b1, 1'b0, -1);
    wait_idle();
    rdy_rand = 1'b0;
    tick();

    // Reset mid-frame during a stall discards everything
    rdy_fixed = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) send_sample(32'h900 + 32'(i));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_tvalid", 64'(out_tvalid), 64'd0);
    chk("midrst_drop", 64'(drop_cnt), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rdy_fixed = 1'b1;
    send_frame(32'hA00, 1'b1, 1'b0, 1'b0, -1);
    wait_idle();

    // Drop counter saturation
    rdy_fixed = 1'b0;
    tick();
    send_frame(32'hB00, 1'b1, 1'b0, 1'b0, -1);
    send_frame(32'hC00, 1'b0, 1'b0, 1'b0, -1);
    chk("sat_drop1", 64'(drop_cnt), 64'd1);
    send_frame(32'hD00, 1'b0, 1'b0, 1'b0, -1);
    chk("sat_drop2", 64'(drop_cnt), 64'd2);
    send_frame(32'hE00, 1'b0, 1'b0, 1'b0, -1);
    chk("sat_drop3", 64'(drop_cnt), 64'd3);
    send_frame(32'hF00, 1'b0, 1'b0, 1'b0, -1);
    chk("sat_hold", 64'(drop_cnt), 64'd3);
    rdy_fixed = 1'b1;
    wait_idle();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
